// File: rtl/cubic_poly_pipe.sv
// Three-stage pipelined evaluator of P(x, c) = x^3 + 2*x^2 + c*x + c on 2-bit unsigned operands.
// Optional macro CUBIC_POLY_VALID_OUT_EN adds a result_valid output that flags each new result.
`timescale 1ns/1ps
module cubic_poly_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] x_in,
  input  logic [1:0] x_in_c,
  output logic [5:0] result_out,
  input  logic       start
`ifdef CUBIC_POLY_VALID_OUT_EN
  ,
  output logic       result_valid
`endif
);

  logic [1:0] x_p0, c_p0;
  logic       vld_p0;
  logic [1:0] x_p1, c_p1;
  logic [3:0] sq_p1;
  logic       vld_p1;

  // Every term is widened to the 6-bit result before summing; P(3,3)=57 is the peak, so no wrap.
  function automatic logic [5:0] poly_sum(input logic [1:0] x, input logic [1:0] c,
                                          input logic [3:0] sq);
    logic [5:0] x6, c6, sq6;
    x6  = {4'b0000, x};
    c6  = {4'b0000, c};
    sq6 = {2'b00, sq};
    return (x6 * sq6) + (sq6 << 1) + (c6 * x6) + c6;
  endfunction

  // Stage 1: capture operands; bubbles keep the old operands so undriven inputs never enter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p0   <= '0;
      c_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= start;
      if (start) begin
        x_p0 <= x_in;
        c_p0 <= x_in_c;
      end
    end
  end

  // Stage 2: square
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1   <= '0;
      c_p1   <= '0;
      sq_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      x_p1   <= x_p0;
      c_p1   <= c_p0;
      sq_p1  <= {2'b00, x_p0} * {2'b00, x_p0};
      vld_p1 <= vld_p0;
    end
  end

  // Stage 3: final sum, updated only for accepted operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_out <= '0;
    end else if (vld_p1) begin
      result_out <= poly_sum(x_p1, c_p1, sq_p1);
    end
  end

`ifdef CUBIC_POLY_VALID_OUT_EN
  logic vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  assign result_valid = vld_p2;
`endif

endmodule

// File: tb/tb_cubic_poly_pipe.sv
// Scoreboard bench for cubic_poly_pipe: driver queues hand-computed results, monitor checks each cycle.
`timescale 1ns/1ps
module tb_cubic_poly_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] x_in, x_in_c;
  logic [5:0] result_out;
  logic       start;
`ifdef CUBIC_POLY_VALID_OUT_EN
  logic       result_valid;
`endif

  cubic_poly_pipe dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_in_c(x_in_c),
    .result_out(result_out), .start(start)
`ifdef CUBIC_POLY_VALID_OUT_EN
    , .result_valid(result_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [5:0] val; } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Hand-computed P(x,c) indexed by x*4+c
  logic [5:0] ptab [16] = '{6'd0,  6'd1,  6'd2,  6'd3,
                            6'd3,  6'd5,  6'd7,  6'd9,
                            6'd16, 6'd19, 6'd22, 6'd25,
                            6'd45, 6'd49, 6'd53, 6'd57};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
  endtask

  // Monitor: sampled 1ns after each rising edge
  initial begin
    logic [5:0] last;
    logic       vexp;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      vexp = 1'b0;
      if (!rst_n) begin
        q.delete();
        last = '0;
      end else begin
        while (q.size() > 0 && q[0].due < cyc) begin
          check("missed_result", 0, 1);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          last = q.pop_front().val;
          vexp = 1'b1;
        end
      end
      check("result_out", int'(result_out), int'(last));
`ifdef CUBIC_POLY_VALID_OUT_EN
      check("result_valid", int'(result_valid), int'(vexp));
`endif
    end
  end

  task automatic drive(input logic s, input logic [1:0] x, input logic [1:0] c);
    exp_t e;
    @(negedge clk);
    start  = s;
    x_in   = x;
    x_in_c = c;
    if (s && rst_n) begin
      e.due = cyc + 3;
      e.val = ptab[{x, c}];
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'(i), 2'(i + 1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; x_in = 2'd3; x_in_c = 2'd3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; start = 1'b0;

    drive(1'b1, 2'd2, 2'd1);            // single op -> 19
    idle(5);

    drive(1'b1, 2'd2, 2'd1);            // back-to-back -> 19, 49
    drive(1'b1, 2'd3, 2'd1);
    idle(5);

    for (int i = 0; i < 16; i++) drive(1'b1, 2'(i / 4), 2'(i % 4));
    idle(4);

    for (int i = 0; i < 8; i++) begin   // bubbles with junk operands while start=0
      drive(1'b1, 2'(i % 4), 2'((i * 3) % 4));
      drive(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    idle(4);

    // Asynchronous clear between edges; last result was P(3,1)=49
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_clear", int'(result_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    drive(1'b1, 2'd3, 2'd3);            // mid-flight reset discards P(3,3)
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
